fuzzy_wavelet: RTL and testbench

Streaming 8-tap wavelet filter. 8-bit signed samples are clocked in by a slow external data strobe. After each new sample a sequential multiply-accumulate runs against one of four selectable integer wavelet kernels, producing a scaled, saturated magnitude and a threshold flag. The block is the top-level user design, so all I/O is packed into io_in/io_out.

---
 rtl/fuzzy_wavelet_if.sv | 18 +
 rtl/fuzzy_wavelet.sv | 134 +++++++++++++
 tb/tb_fuzzy_wavelet.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fuzzy_wavelet_if.sv
// Sample/select/result bundle between the pin-level wrapper and the wavelet core.
interface fuzzy_wavelet_if;
  logic       i_data_clk;
  logic [7:0] i_value;
  logic [7:0] i_select;
  logic [7:0] fw_out;
  logic       o_active;

  modport master (
    output i_data_clk, i_value, i_select,
    input  fw_out, o_active
  );

  modport slave (
    input  i_data_clk, i_value, i_select,
    output fw_out, o_active
  );
endinterface

// File: rtl/fuzzy_wavelet.sv
// Streaming 8-tap integer wavelet filter: strobe-synchronised sample buffer,
// sequential MAC over a selectable kernel, scaled saturated magnitude + threshold flag.
module fuzzy_wavelet_core #(
  parameter int NTAPS = 8,
  parameter int ACC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fuzzy_wavelet_if.slave  bus
);
  localparam int TAP_W = $clog2(NTAPS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                    r_state;
  logic [2:0]                r_sync;
  logic [1:0]                r_warm;
  logic                      r_armed;
  logic signed [7:0]         r_samp [NTAPS];
  logic [7:0]                r_sel;
  logic [TAP_W-1:0]          r_tap;
  logic signed [ACC_W-1:0]   r_acc;
  logic [7:0]                r_fw;
  logic                      r_act;

  logic                      w_shift;
  logic [31:0]               w_tbl;
  logic [3:0]                w_coef;
  logic [7:0]                w_samp;
  logic [11:0]               w_prod;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic [ACC_W-1:0]          w_abs;
  logic [ACC_W-1:0]          w_mag;
  logic [7:0]                w_sat;
  logic                      w_act;

  // A strobe already high when reset releases must not count as an edge:
  // shifting is only enabled once the settled chain has seen the strobe low.
  assign w_shift = r_sync[1] & ~r_sync[2] & r_armed;

  // Kernels packed one 4-bit signed coefficient per nibble, nibble k = tap k.
  always_comb begin
    w_tbl = '0;
    unique case (r_sel[1:0])
      2'd0: w_tbl = 32'hFFFF_1111;
      2'd1: w_tbl = 32'hFD13_31DF;
      2'd2: w_tbl = 32'h0000_00F1;
      2'd3: w_tbl = 32'hD030_D030;
      default: w_tbl = '0;
    endcase
  end

  assign w_coef = w_tbl[{r_tap, 2'b00} +: 4];
  assign w_samp = r_samp[r_tap];
  // Low 12 bits of a two's-complement product do not depend on operand signedness.
  assign w_prod = {{8{w_coef[3]}}, w_coef} * {{4{w_samp[7]}}, w_samp};
  assign w_acc_next = r_acc + {{(ACC_W-12){w_prod[11]}}, w_prod};

  assign w_abs = r_acc[ACC_W-1] ? ACC_W'(-r_acc) : ACC_W'(r_acc);
  assign w_mag = w_abs >> r_sel[4:2];
  assign w_sat = (|w_mag[ACC_W-1:8]) ? 8'hFF : w_mag[7:0];
  assign w_act = w_sat > {r_sel[7:5], 5'b0_0000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sync  <= '0;
      r_warm  <= '0;
      r_armed <= 1'b0;
      for (int unsigned k = 0; k < NTAPS; k++) r_samp[k] <= '0;
      r_sel   <= '0;
      r_tap   <= '0;
      r_acc   <= '0;
      r_fw    <= '0;
      r_act   <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], bus.i_data_clk};
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
      else if (!r_sync[1]) r_armed <= 1'b1;

      if (r_state == ST_DONE) begin
        r_fw  <= w_sat;
        r_act <= w_act;
      end

      // A new sample always wins: any MAC in flight is discarded unreported.
      if (w_shift) begin
        for (int unsigned k = NTAPS - 1; k > 0; k--) r_samp[k] <= r_samp[k-1];
        r_samp[0] <= bus.i_value;
        r_sel     <= bus.i_select;
        r_acc     <= '0;
        r_tap     <= '0;
        r_state   <= ST_RUN;
      end else begin
        unique case (r_state)
          ST_RUN: begin
            r_acc <= w_acc_next;
            r_tap <= r_tap + TAP_W'(1);
            if (r_tap == TAP_W'(NTAPS - 1)) r_state <= ST_DONE;
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.fw_out   = r_fw;
  assign bus.o_active = r_act;
endmodule

module fuzzy_wavelet #(
  parameter int NTAPS = 8,
  parameter int ACC_W = 16
) (
  input  logic [18:0] io_in,
  output logic [8:0]  io_out
);
  fuzzy_wavelet_if u_bus ();

  assign u_bus.i_data_clk = io_in[2];
  assign u_bus.i_value    = io_in[10:3];
  assign u_bus.i_select   = io_in[18:11];
  assign io_out           = {u_bus.o_active, u_bus.fw_out};

  fuzzy_wavelet_core #(
    .NTAPS(NTAPS),
    .ACC_W(ACC_W)
  ) u_core (
    .clk   (io_in[0]),
    .rst_n (io_in[1]),
    .bus   (u_bus.slave)
  );
endmodule

// File: tb/tb_fuzzy_wavelet.sv
// Directed bench for fuzzy_wavelet: hand-computed kernel results, latency, abort and reset cases.
module tb_fuzzy_wavelet;
  logic        clk;
  logic        rst_n;
  logic [18:0] io_in;
  logic [8:0]  io_out;
  int          total = 0;
  int          bad   = 0;

  fuzzy_wavelet_if tb_bus ();

  assign io_in = {tb_bus.i_select, tb_bus.i_value, tb_bus.i_data_clk, rst_n, clk};
  assign tb_bus.fw_out   = io_out[7:0];
  assign tb_bus.o_active = io_out[8];

  fuzzy_wavelet #(.NTAPS(8), .ACC_W(16)) dut (.io_in(io_in), .io_out(io_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  // Rise at a negedge, hold high 3 clk, drop; returns at the negedge after E2.
  task automatic strobe(input logic [7:0] v, input logic [7:0] s);
    @(negedge clk);
    tb_bus.i_value    = v;
    tb_bus.i_select   = s;
    tb_bus.i_data_clk = 1'b1;
    repeat (3) @(negedge clk);
    tb_bus.i_data_clk = 1'b0;
  endtask

  // Returns at the negedge after E11, i.e. with the new result visible.
  task automatic push(input logic [7:0] v, input logic [7:0] s);
    strobe(v, s);
    repeat (9) @(negedge clk);
  endtask

  task automatic push_n(input logic [7:0] v, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) push(v, s);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tb_bus.i_data_clk = 1'b1;
    tb_bus.i_value    = 8'($urandom);
    tb_bus.i_select   = 8'($urandom);
    repeat (3) @(negedge clk);
    total++; if (tb_bus.fw_out !== 8'd0) begin bad++; $display("FAIL reset_fw: got %0d want 0", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b0) begin bad++; $display("FAIL reset_act: got %b want 0", tb_bus.o_active); end
    rst_n = 1'b1;
    tb_bus.i_value  = 8'd100;
    tb_bus.i_select = 8'h00;
    repeat (15) @(negedge clk);
    total++; if (tb_bus.fw_out !== 8'd0) begin bad++; $display("FAIL strobe_high_at_release_fw: got %0d want 0", tb_bus.fw_out); end
    tb_bus.i_data_clk = 1'b0;
    repeat (15) @(negedge clk);
    total++; if (tb_bus.fw_out !== 8'd0) begin bad++; $display("FAIL idle_fw: got %0d want 0", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b0) begin bad++; $display("FAIL idle_act: got %b want 0", tb_bus.o_active); end
  endtask

  task automatic test_haar;
    push_n(8'd10, 8'h00, 8);
    total++; if (tb_bus.fw_out !== 8'd0) begin bad++; $display("FAIL haar_flat_fw: got %0d want 0", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b0) begin bad++; $display("FAIL haar_flat_act: got %b want 0", tb_bus.o_active); end
    push_n(8'd50, 8'h00, 3);
    total++; if (tb_bus.fw_out !== 8'd120) begin bad++; $display("FAIL haar_step3_fw: got %0d want 120", tb_bus.fw_out); end
    strobe(8'd50, 8'h00);
    repeat (8) @(negedge clk);
    total++; if (tb_bus.fw_out !== 8'd120) begin bad++; $display("FAIL haar_latency_e10_fw: got %0d want 120", tb_bus.fw_out); end
    @(negedge clk);
    total++; if (tb_bus.fw_out !== 8'd160) begin bad++; $display("FAIL haar_160_fw: got %0d want 160", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b1) begin bad++; $display("FAIL haar_160_act: got %b want 1", tb_bus.o_active); end
  endtask

  task automatic test_shift_thr;
    push_n(8'd10, 8'h00, 8);
    push_n(8'd50, 8'h00, 3);
    push(8'd50, 8'h08);
    total++; if (tb_bus.fw_out !== 8'd40) begin bad++; $display("FAIL shift2_fw: got %0d want 40", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b1) begin bad++; $display("FAIL shift2_act: got %b want 1", tb_bus.o_active); end
    push(8'd90, 8'hA0);
    total++; if (tb_bus.fw_out !== 8'd160) begin bad++; $display("FAIL thr_eq_fw: got %0d want 160", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b0) begin bad++; $display("FAIL thr_eq_act: got %b want 0", tb_bus.o_active); end
    push(8'd91, 8'hA0);
    total++; if (tb_bus.fw_out !== 8'd161) begin bad++; $display("FAIL thr_above_fw: got %0d want 161", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b1) begin bad++; $display("FAIL thr_above_act: got %b want 1", tb_bus.o_active); end
  endtask

  task automatic test_saturation;
    push_n(8'h80, 8'h00, 4);
    push_n(8'h7F, 8'h00, 4);
    total++; if (tb_bus.fw_out !== 8'd255) begin bad++; $display("FAIL sat_fw: got %0d want 255", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b1) begin bad++; $display("FAIL sat_act: got %b want 1", tb_bus.o_active); end
    push_n(8'h80, 8'h00, 4);
    push_n(8'h7F, 8'h00, 3);
    push(8'h7F, 8'h0C);
    total++; if (tb_bus.fw_out !== 8'd127) begin bad++; $display("FAIL sat_shift3_fw: got %0d want 127", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b1) begin bad++; $display("FAIL sat_shift3_act: got %b want 1", tb_bus.o_active); end
  endtask

  task automatic test_fine;
    push_n(8'd20, 8'h02, 8);
    push(8'd60, 8'h02);
    total++; if (tb_bus.fw_out !== 8'd40) begin bad++; $display("FAIL fine_step_fw: got %0d want 40", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b1) begin bad++; $display("FAIL fine_step_act: got %b want 1", tb_bus.o_active); end
    push(8'd60, 8'h02);
    total++; if (tb_bus.fw_out !== 8'd0) begin bad++; $display("FAIL fine_flat_fw: got %0d want 0", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b0) begin bad++; $display("FAIL fine_flat_act: got %b want 0", tb_bus.o_active); end
  endtask

  task automatic test_back_to_back;
    strobe(8'd30, 8'h02);
    @(negedge clk);
    strobe(8'd100, 8'h02);
    repeat (8) @(negedge clk);
    total++; if (tb_bus.fw_out !== 8'd0) begin bad++; $display("FAIL b2b_held_fw: got %0d want 0", tb_bus.fw_out); end
    @(negedge clk);
    total++; if (tb_bus.fw_out !== 8'd70) begin bad++; $display("FAIL b2b_fw: got %0d want 70", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b1) begin bad++; $display("FAIL b2b_act: got %b want 1", tb_bus.o_active); end
  endtask

  task automatic test_reset_mid_mac;
    strobe(8'd10, 8'h02);
    repeat (3) @(negedge clk);
    total++; if (tb_bus.fw_out !== 8'd70) begin bad++; $display("FAIL pre_reset_fw: got %0d want 70", tb_bus.fw_out); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (tb_bus.fw_out !== 8'd0) begin bad++; $display("FAIL async_reset_fw: got %0d want 0", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b0) begin bad++; $display("FAIL async_reset_act: got %b want 0", tb_bus.o_active); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    total++; if (tb_bus.fw_out !== 8'd0) begin bad++; $display("FAIL post_reset_idle_fw: got %0d want 0", tb_bus.fw_out); end
    push(8'd40, 8'h02);
    total++; if (tb_bus.fw_out !== 8'd40) begin bad++; $display("FAIL post_reset_push_fw: got %0d want 40", tb_bus.fw_out); end
    total++; if (tb_bus.o_active !== 1'b1) begin bad++; $display("FAIL post_reset_push_act: got %b want 1", tb_bus.o_active); end
  endtask

  initial begin
    rst_n = 1'b0;
    tb_bus.i_data_clk = 1'b0;
    tb_bus.i_value    = '0;
    tb_bus.i_select   = '0;
    test_reset();
    test_haar();
    test_shift_thr();
    test_saturation();
    test_fine();
    test_back_to_back();
    test_reset_mid_mac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
